qspi_flash_responder: RTL

QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

---
 rtl/qspi_flash_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: quad-I/O fast-read (0xEB) flash responder backed by an internal byte ROM.
module qspi_flash_responder #(
  parameter int ROM_ADDR_BITS = 12,
  parameter int DUMMY_NIBBLES = 6,
  parameter string INIT_FILE = "rom.hex"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic [3:0] spi_io_in,
  output logic [3:0] spi_io_out,
  output logic [3:0] spi_io_oe
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  state_t state, state_n;
  logic [7:0] rom [0:(1<<ROM_ADDR_BITS)-1];
  logic cs_m, cs_s, cs_d, sck_m, sck_s, sck_d;
  logic [3:0] io_m, io_s, shreg, out;
  logic [7:0] cnt, rom_q;
  logic [23:0] addr;
  logic drv, nib_lo, cont_mode;
  logic cs_fall, cs_rise, sck_rise, sck_fall, data_fall;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {cs_m, cs_s, cs_d} <= 3'b111;
      {sck_m, sck_s, sck_d} <= 3'b000;
      io_m <= '0;
      io_s <= '0;
    end else begin
      {cs_m, cs_s, cs_d} <= {spi_cs_n, cs_m, cs_s};
      {sck_m, sck_s, sck_d} <= {spi_sck, sck_m, sck_s};
      io_m <= spi_io_in;
      io_s <= io_m;
    end
  end
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign sck_rise = sck_s & ~sck_d & ~cs_s & ~cs_fall;
  assign sck_fall = ~sck_s & sck_d & ~cs_s & ~cs_fall;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (cs_rise) state_n = IDLE;
    else
      case (state)
        IDLE:  if (cs_fall) state_n = cont_mode ? ADDR : CMD;
        CMD:   if (sck_rise && cnt == 8'd1) state_n = ({shreg, io_s} == 8'hEB) ? ADDR : IGNORE;
        ADDR:  if (sck_rise && cnt == 8'd5) state_n = DUMMY;
        DUMMY: if (sck_rise && cnt == 8'(DUMMY_NIBBLES - 1)) state_n = DATA;
        default: state_n = state;
      endcase
  end
  always_comb begin
    data_fall = state == DATA && sck_fall;
    spi_io_oe = {4{drv && state == DATA && !cs_rise}};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      shreg <= '0;
      addr <= '0;
      out <= '0;
      drv <= 1'b0;
      nib_lo <= 1'b0;
    end else begin
      cnt <= (state_n != state) ? '0 : cnt + {7'd0, sck_rise};
      if (state == CMD && sck_rise) shreg <= io_s;
      if (cs_fall) addr <= '0;
      else if (state == ADDR && sck_rise) addr <= {addr[19:0], io_s};
      else if (data_fall && nib_lo) addr <= addr + 24'd1;
      if (data_fall) begin
        out <= nib_lo ? rom_q[3:0] : rom_q[7:4];
        nib_lo <= ~nib_lo;
        drv <= 1'b1;
      end else if (state != DATA) begin
        drv <= 1'b0;
        nib_lo <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) rom_q <= rom[addr[ROM_ADDR_BITS-1:0]];
  assign spi_io_out = out;
`ifdef QSPI_RESP_CONT_READ_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) cont_mode <= 1'b0;
    else if (state == DUMMY && sck_rise && cnt == 8'd0) cont_mode <= io_s == 4'hA;
`else
  assign cont_mode = 1'b0;
`endif
endmodule
